// File: rtl/count_seq_pkg.sv
// Shared definitions for the command-driven count sequencer:
// host op-codes and the controller state encoding.
package count_seq_pkg;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_PAUSE  = 2'd1;
  localparam logic [1:0] OP_RESUME = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler for the count sequencer. Produces a one-cycle enable (not a
// derived clock) every 2^N cycles in which run_i is high. The divider
// freezes while run_i is low so phase survives pause/resume, and clr_i
// forces it back to zero.
module tick_gen #(
  parameter int N = 22
) (
  input  logic clk,
  input  logic rstn,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o
);

  logic [N-1:0] divider_q;
  logic [N-1:0] divider_d;

  // Next divider value: clear wins, otherwise count only while running
  always_comb begin
    divider_d = divider_q;
    if (clr_i) begin
      divider_d = '0;
    end else if (run_i) begin
      divider_d = divider_q + N'(1);
    end
  end

  // Divider register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      divider_q <= '0;
    end else begin
      divider_q <= divider_d;
    end
  end

  assign tick_o = run_i && (divider_q == {N{1'b1}});

endmodule

// File: rtl/count_sequencer.sv
// Command-driven controller for the prescaled counter. Host commands
// (START/PAUSE/RESUME/CLEAR) arrive over a valid/ready handshake; the
// counter advances by one on every prescaler tick until it reaches the
// programmed target.
// Optional build macro AUTO_RELOAD_EN: on reaching the target the counter
// restarts from zero and keeps running instead of stopping in DONE.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int N = 22,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_arg,
  output logic [W-1:0] data,
  output logic         tick,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] target_q, target_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;

  logic cmdAccept;
  logic runEn;
  logic divClr;
  logic tickEn;

  assign cmdAccept = cmd_valid && ready_q;
  assign runEn     = (state_q == S_RUN);

  // Divider restarts on START/CLEAR and is parked at zero when not counting
  assign divClr = (cmdAccept && ((cmd_op == OP_START) || (cmd_op == OP_CLEAR)))
                  || (state_q == S_IDLE) || (state_q == S_DONE);

  tick_gen #(
    .N(N)
  ) u_tick_gen (
    .clk   (clk),
    .rstn  (rstn),
    .run_i (runEn),
    .clr_i (divClr),
    .tick_o(tickEn)
  );

  // Next-state logic: an accepted command always takes priority over a tick
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    target_d = target_q;
    done_d   = 1'b0;
    ready_d  = !cmdAccept;

    if (cmdAccept) begin
      case (cmd_op)
        OP_START: begin
          target_d = cmd_arg;
          data_d   = '0;
          state_d  = S_RUN;
        end
        OP_PAUSE: begin
          if (state_q == S_RUN) state_d = S_PAUSE;
        end
        OP_RESUME: begin
          if (state_q == S_PAUSE) state_d = S_RUN;
        end
        default: begin
          data_d  = '0;
          state_d = S_IDLE;
        end
      endcase
    end else if (tickEn) begin
      if (data_q == target_q) begin
        done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
        data_d = '0;
`else
        state_d = S_DONE;
`endif
      end else begin
        data_d = data_q + W'(1);
      end
    end
  end

  // Controller registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      target_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      target_q <= target_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready = ready_q;
  assign data      = data_q;
  assign tick      = tickEn;
  assign busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done      = done_q;

endmodule
